// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the fetch PC, keeps one imem request in flight and
// hands {pc, inst} to IF/ID. Define IFU_PERF_EN to add fetch/drop performance counters.
module ifu_fetch #(
    parameter int PC_WIDTH = 64,
    parameter int INST_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(64'h8000_0000)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [PC_WIDTH-1:0]   imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [INST_WIDTH-1:0] imem_rsp_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PC_WIDTH-1:0]   out_pc,
    output logic [INST_WIDTH-1:0] out_inst,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc
`ifdef IFU_PERF_EN
    ,
    output logic [63:0]           perf_fetch_cnt,
    output logic [63:0]           perf_drop_cnt
`endif
);

    // state | meaning
    // IDLE  | first cycle after reset
    // REQ   | presenting request for pc
    // WAIT  | request accepted, awaiting response
    // HOLD  | instruction presented to IF/ID
    // DROP  | awaiting a wrong-path response to discard
    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_t;

    state_t                state, state_next;
    logic [PC_WIDTH-1:0]   pc, pc_next;
    logic [PC_WIDTH-1:0]   out_pc_next;
    logic [INST_WIDTH-1:0] out_inst_next;
    logic                  req_fire;

    assign imem_req_valid = (state == REQ);
    assign imem_req_addr  = pc;
    assign out_valid      = (state == HOLD) && !redirect_valid;
    assign req_fire       = imem_req_valid && imem_req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            out_pc   <= '0;
            out_inst <= '0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            out_pc   <= out_pc_next;
            out_inst <= out_inst_next;
        end
    end

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        out_pc_next   = out_pc;
        out_inst_next = out_inst;
        case (state)
            IDLE: state_next = REQ;
            REQ: begin
                if (redirect_valid) begin
                    pc_next = redirect_pc;
                    if (req_fire) state_next = DROP;
                end else if (req_fire) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_next    = redirect_pc;
                    state_next = imem_rsp_valid ? REQ : DROP;
                end else if (imem_rsp_valid) begin
                    out_pc_next   = pc;
                    out_inst_next = imem_rsp_data;
                    state_next    = HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_next    = redirect_pc;
                    state_next = REQ;
                end else if (out_ready) begin
                    pc_next    = pc + PC_WIDTH'(4);
                    state_next = REQ;
                end
            end
            DROP: begin
                // A redirect here only retargets pc; the stale response still has to be consumed.
                if (redirect_valid) pc_next = redirect_pc;
                if (imem_rsp_valid) state_next = REQ;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef IFU_PERF_EN
    logic fetch_evt, drop_evt;

    assign fetch_evt = out_valid && out_ready;
    assign drop_evt  = (imem_rsp_valid && ((state == WAIT && redirect_valid) || state == DROP))
                     || (state == HOLD && redirect_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_drop_cnt  <= '0;
        end else begin
            if (fetch_evt) perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
            if (drop_evt)  perf_drop_cnt  <= perf_drop_cnt + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: cycle vector table plus hand sequences for stalls and redirects,
// with an instruction memory model and an expected-output scoreboard.
module tb_ifu_fetch;

    logic        clk = 0;
    logic        rst = 1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 0;
    logic [31:0] imem_rsp_data;
    logic        out_valid;
    logic        out_ready = 1;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic        redirect_valid = 0;
    logic [63:0] redirect_pc = '0;
`ifdef IFU_PERF_EN
    logic [63:0] perf_fetch_cnt, perf_drop_cnt;
`endif

    ifu_fetch dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef IFU_PERF_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_drop_cnt(perf_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    // memory model: responds mem_lat cycles after each accepted request
    int          mem_lat = 1;
    int          mem_cnt = 0;
    int          hs_count = 0;
    logic [63:0] mem_addr = '0;
    assign imem_rsp_data = inst_of(mem_addr);

    always @(posedge clk) begin
        if (rst) begin
            mem_cnt = 0;
        end else begin
            if (mem_cnt > 0) mem_cnt--;
            if (imem_req_valid && imem_req_ready) begin
                mem_cnt  = mem_lat;
                mem_addr = imem_req_addr;
                hs_count++;
            end
        end
        #1;
        imem_rsp_valid = (mem_cnt == 1);
    end

    // scoreboard of instructions expected to be accepted by IF/ID
    logic [63:0] exp_q[$];

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected: got pc=%h inst=%h, required no output", out_pc, out_inst);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if (out_pc !== e || out_inst !== inst_of(e)) begin
                    n_bad++;
                    $display("FAIL sb_out: got pc=%h inst=%h, required pc=%h inst=%h",
                             out_pc, out_inst, e, inst_of(e));
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        chk("sb_leftover", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        rst = 1;
        redirect_valid = 0;
        imem_req_ready = 1;
        out_ready = 1;
        mem_lat = 1;
        @(posedge clk);
        @(negedge clk);
        chk("reset_state", {60'd0, imem_req_valid, out_valid, |out_pc, |out_inst}, 64'd0);
        next_cycle();
        rst = 0;
    endtask

    task automatic wait_ov(input string name);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) return;
            next_cycle();
        end
        n_vec++;
        n_bad++;
        $display("FAIL %s: got no out_valid within 12 cycles, required out_valid", name);
    endtask

    typedef struct {
        logic        ordy;
        logic        rd_v;
        logic [63:0] rd_pc;
        logic        exp_rv;
        logic [63:0] exp_addr;
        logic        exp_ov;
        logic [63:0] exp_opc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rdv, input logic [63:0] rdpc, input logic rv,
                       input logic [63:0] addr, input logic ov, input logic [63:0] opc);
        vec_t v;
        v.ordy = 1; v.rd_v = rdv; v.rd_pc = rdpc;
        v.exp_rv = rv; v.exp_addr = addr; v.exp_ov = ov; v.exp_opc = opc;
        vecs.push_back(v);
    endtask

    initial begin
        int hs0;
        // sequential fetch, HOLD redirect, accepted-REQ redirect and PC wrap
        add(0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 64'h8000_0000, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 64'h8000_0000);
        add(0, 0, 1, 64'h8000_0004, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 64'h8000_0004);
        add(0, 0, 1, 64'h8000_0008, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 64'h8000_0008);
        add(0, 0, 1, 64'h8000_000C, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        add(1, 64'h8000_0200, 0, 0, 0, 0);
        add(0, 0, 1, 64'h8000_0200, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 64'h8000_0200);
        add(1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 64'h8000_0204, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        add(0, 0, 1, 64'h0, 0, 0);

        do_reset();
        exp_q.push_back(64'h8000_0000);
        exp_q.push_back(64'h8000_0004);
        exp_q.push_back(64'h8000_0008);
        exp_q.push_back(64'h8000_0200);
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
        foreach (vecs[i]) begin
            out_ready      = vecs[i].ordy;
            redirect_valid = vecs[i].rd_v;
            redirect_pc    = vecs[i].rd_pc;
            @(negedge clk);
            n_vec++;
            if (imem_req_valid !== vecs[i].exp_rv ||
                (vecs[i].exp_rv && imem_req_addr !== vecs[i].exp_addr) ||
                out_valid !== vecs[i].exp_ov ||
                (vecs[i].exp_ov && out_pc !== vecs[i].exp_opc)) begin
                n_bad++;
                $display("FAIL vec%0d: got rv=%b addr=%h ov=%b pc=%h, required rv=%b addr=%h ov=%b pc=%h",
                         i, imem_req_valid, imem_req_addr, out_valid, out_pc,
                         vecs[i].exp_rv, vecs[i].exp_addr, vecs[i].exp_ov, vecs[i].exp_opc);
            end
            next_cycle();
        end
        redirect_valid = 0;

        // decode stall: held output stable, no new request
        do_reset();
        out_ready = 0;
        exp_q.push_back(64'h8000_0000);
        wait_ov("stall_first");
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                next_cycle();
                @(negedge clk);
            end
            chk("stall_hold", {62'd0, out_valid, imem_req_valid}, 64'b10);
            chk("stall_pc", out_pc, 64'h8000_0000);
            chk("stall_inst", {32'd0, out_inst}, {32'd0, inst_of(64'h8000_0000)});
        end
        next_cycle();
        out_ready = 1;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        chk("stall_next_req", {imem_req_addr[62:0], imem_req_valid}, {63'h8000_0004, 1'b1});

        // three fetches, then redirect in WAIT with a 2-cycle response, then reset mid-WAIT
        do_reset();
        exp_q.push_back(64'h8000_0000);
        exp_q.push_back(64'h8000_0004);
        exp_q.push_back(64'h8000_0008);
        for (int k = 0; k < 3; k++) begin
            wait_ov("seq_out");
            next_cycle();
        end
        mem_lat = 2;
        @(negedge clk);
        chk("wait_rd_req", {imem_req_addr[62:0], imem_req_valid}, {63'h8000_000C, 1'b1});
        next_cycle();
        redirect_valid = 1;
        redirect_pc = 64'h8000_0100;
        @(negedge clk);
        chk("wait_rd_ov", {62'd0, out_valid, imem_req_valid}, 64'd0);
        next_cycle();
        redirect_valid = 0;
        @(negedge clk);
        chk("drop_quiet", {62'd0, out_valid, imem_req_valid}, 64'd0);
        next_cycle();
        @(negedge clk);
        chk("drop_next_req", {imem_req_addr[62:0], imem_req_valid}, {63'h8000_0100, 1'b1});
`ifdef IFU_PERF_EN
        chk("perf_fetch", perf_fetch_cnt, 64'd3);
        chk("perf_drop", perf_drop_cnt, 64'd1);
`endif
        next_cycle();
        rst = 1;
        next_cycle();
        rst = 0;
        @(negedge clk);
        chk("rst_wait_idle", {62'd0, out_valid, imem_req_valid}, 64'd0);
`ifdef IFU_PERF_EN
        chk("perf_rst", perf_fetch_cnt | perf_drop_cnt, 64'd0);
`endif
        next_cycle();
        @(negedge clk);
        chk("rst_wait_req", {imem_req_addr[62:0], imem_req_valid}, {63'h8000_0000, 1'b1});
        next_cycle();

        // request held off by imem, redirect while unaccepted
        do_reset();
        imem_req_ready = 0;
        hs0 = hs_count;
        next_cycle();
        @(negedge clk);
        chk("bp_c1", {imem_req_addr[62:0], imem_req_valid}, {63'h8000_0000, 1'b1});
        next_cycle();
        redirect_valid = 1;
        redirect_pc = 64'h8000_0300;
        @(negedge clk);
        chk("bp_c2", {imem_req_addr[62:0], imem_req_valid}, {63'h8000_0000, 1'b1});
        next_cycle();
        redirect_valid = 0;
        @(negedge clk);
        chk("bp_c3", {imem_req_addr[62:0], imem_req_valid}, {63'h8000_0300, 1'b1});
        next_cycle();
        @(negedge clk);
        chk("bp_c4", {imem_req_addr[62:0], imem_req_valid}, {63'h8000_0300, 1'b1});
        next_cycle();
        imem_req_ready = 1;
        exp_q.push_back(64'h8000_0300);
        wait_ov("bp_out");
        chk("bp_handshakes", 64'(hs_count - hs0), 64'd1);
        next_cycle();
        next_cycle();

        chk("sb_final", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
